// File: rtl/pipe_skid_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer and flush.
// Control field is zeroed on bubbles so a stray write enable never reaches write-back.
module pipe_skid_stage_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CTRL_W  = 3,
    parameter int unsigned SKID_EN = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Flush,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [DATA_W-1:0] i_Data,
    input  logic [CTRL_W-1:0] i_Ctrl,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [DATA_W-1:0] o_Data,
    output logic [CTRL_W-1:0] o_Ctrl,
    output logic [1:0]        o_Occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              ready_en;
    logic              accept_c;
    logic              emit_c;
    logic              load_in;
    logic              load_skid;
    logic              load_from_skid;
    logic              valid_c;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // ready_en keeps o_Ready low during reset and for the release cycle
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= ST_EMPTY;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
        end
    end

    assign valid_c  = (state != ST_EMPTY);
    assign emit_c   = valid_c & i_Ready;
    assign accept_c = i_Valid & o_Ready;

    // With the skid, ready comes from registered state only; without it, it looks through to i_Ready
    assign o_Ready = ready_en & ((SKID_EN != 0) ? (state != ST_FULL)
                                                : (!valid_c | i_Ready));

    // Next state and datapath load strobes; flush wins over accept and emit
    always_comb begin
        state_nxt      = state;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        if (i_Flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_nxt = ST_BUSY;
                        load_in   = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept_c && emit_c) begin
                        load_in = 1'b1;
                    end else if (accept_c && (SKID_EN != 0)) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (emit_c) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit_c) begin
                        state_nxt      = ST_BUSY;
                        load_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        o_Occupancy = 2'd0;
        case (state)
            ST_EMPTY: o_Occupancy = 2'd0;
            ST_BUSY:  o_Occupancy = 2'd1;
            ST_FULL:  o_Occupancy = 2'd2;
            default:  o_Occupancy = 2'd0;
        endcase
        o_Valid = valid_c;
        o_Data  = main_data;
        o_Ctrl  = valid_c ? main_ctrl : CTRL_W'(0);
    end

    // Main (output) register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            main_data <= '0;
            main_ctrl <= '0;
        end else if (load_in) begin
            main_data <= i_Data;
            main_ctrl <= i_Ctrl;
        end else if (load_from_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
        end
    end

    // Skid register catches the entry accepted while downstream stalls
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (load_skid) begin
            skid_data <= i_Data;
            skid_ctrl <= i_Ctrl;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage_reg.sv
// Bench for pipe_skid_stage_reg: queue-based reference model for a skid and a non-skid instance,
// directed scenarios with literal expectations, then a long random run.
module tb_pipe_skid_stage_reg;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        flush_a = 1'b0, vin_a = 1'b0, rdy_in_a = 1'b1;
    logic [31:0] din_a = '0;
    logic [2:0]  cin_a = '0;
    logic        rdy_out_a, vout_a;
    logic [31:0] dout_a;
    logic [2:0]  cout_a;
    logic [1:0]  occ_a;

    logic        flush_b = 1'b0, vin_b = 1'b0, rdy_in_b = 1'b1;
    logic [31:0] din_b = '0;
    logic [2:0]  cin_b = '0;
    logic        rdy_out_b, vout_b;
    logic [31:0] dout_b;
    logic [2:0]  cout_b;
    logic [1:0]  occ_b;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pipe_skid_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID_EN(1)) u_a (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Flush(flush_a),
        .i_Valid(vin_a), .o_Ready(rdy_out_a), .i_Data(din_a), .i_Ctrl(cin_a),
        .o_Valid(vout_a), .i_Ready(rdy_in_a), .o_Data(dout_a), .o_Ctrl(cout_a),
        .o_Occupancy(occ_a)
    );

    pipe_skid_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID_EN(0)) u_b (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Flush(flush_b),
        .i_Valid(vin_b), .o_Ready(rdy_out_b), .i_Data(din_b), .i_Ctrl(cin_b),
        .o_Valid(vout_b), .i_Ready(rdy_in_b), .o_Data(dout_b), .o_Ctrl(cout_b),
        .o_Occupancy(occ_b)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: each stage is a FIFO of held entries (capacity 2 with skid, 1 without)
    ent_t qa[$];
    ent_t qb[$];
    bit   ren_a = 1'b0, ren_b = 1'b0;
    bit   acc_a_last = 1'b0, acc_b_last = 1'b0;
    int   emitted_b = 0;

    function automatic bit exp_rdy_a();
        return ren_a && (qa.size() < 2);
    endfunction

    function automatic bit exp_rdy_b();
        return ren_b && ((qb.size() == 0) || rdy_in_b);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_a
        bit acc, emt;
        if (!rst_n) begin
            qa.delete();
            ren_a      = 1'b0;
            acc_a_last = 1'b0;
        end else begin
            acc = vin_a && exp_rdy_a();
            emt = (qa.size() > 0) && rdy_in_a;
            acc_a_last = acc;
            if (flush_a) qa.delete();
            else begin
                if (emt) void'(qa.pop_front());
                if (acc) qa.push_back('{d: din_a, c: cin_a});
            end
            ren_a = 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin : model_b
        bit acc, emt;
        if (!rst_n) begin
            qb.delete();
            ren_b      = 1'b0;
            acc_b_last = 1'b0;
        end else begin
            acc = vin_b && exp_rdy_b();
            emt = (qb.size() > 0) && rdy_in_b;
            acc_b_last = acc;
            if (flush_b) qb.delete();
            else begin
                if (emt) begin
                    void'(qb.pop_front());
                    emitted_b++;
                end
                if (acc) qb.push_back('{d: din_b, c: cin_b});
            end
            ren_b = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : compare
        bit va, vb;
        if (chk_on) begin
            va = qa.size() > 0;
            vb = qb.size() > 0;
            check("a_valid", 32'(vout_a), 32'(va));
            check("a_ready", 32'(rdy_out_a), 32'(exp_rdy_a()));
            check("a_occ", 32'(occ_a), 32'(qa.size()));
            check("a_ctrl", 32'(cout_a), va ? 32'(qa[0].c) : 32'd0);
            if (va) check("a_data", dout_a, qa[0].d);
            check("b_valid", 32'(vout_b), 32'(vb));
            check("b_ready", 32'(rdy_out_b), 32'(exp_rdy_b()));
            check("b_occ", 32'(occ_b), 32'(qb.size()));
            check("b_ctrl", 32'(cout_b), vb ? 32'(qb[0].c) : 32'd0);
            if (vb) check("b_data", dout_b, qb[0].d);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [31:0] d, input logic r);
        vin_a    = v;
        din_a    = d;
        cin_a    = d[2:0];
        rdy_in_a = r;
    endtask

    initial begin
        int pushed;
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        step();
        step();
        // Literal reset state
        check("rst_ready", 32'(rdy_out_a), 32'd0);
        check("rst_valid", 32'(vout_a), 32'd0);
        check("rst_data", dout_a, 32'd0);
        check("rst_ctrl", 32'(cout_a), 32'd0);
        check("rst_occ", 32'(occ_a), 32'd0);
        rst_n = 1'b1;
        step();
        check("rel_ready", 32'(rdy_out_a), 32'd1);

        // Stream of four entries, ctrl 3'b101, downstream always ready
        for (int i = 0; i < 4; i++) begin
            vin_a = 1'b1; din_a = 32'h10 + 32'(i); cin_a = 3'b101; rdy_in_a = 1'b1;
            step();
            check("str_data", dout_a, 32'h10 + 32'(i));
            check("str_ctrl", 32'(cout_a), 32'd5);
            check("str_occ", 32'(occ_a), 32'd1);
        end
        vin_a = 1'b0;
        step();
        check("str_idle_valid", 32'(vout_a), 32'd0);
        check("str_idle_ctrl", 32'(cout_a), 32'd0);

        // Back-pressure: second entry lands in the skid, drains in order
        drive_a(1'b1, 32'h20, 1'b1); step();
        drive_a(1'b1, 32'h21, 1'b0); step();
        check("bp_ready", 32'(rdy_out_a), 32'd0);
        check("bp_occ", 32'(occ_a), 32'd2);
        check("bp_data", dout_a, 32'h20);
        drive_a(1'b1, 32'h22, 1'b0); step();
        check("bp_hold1", dout_a, 32'h20);
        step();
        check("bp_hold2", dout_a, 32'h20);
        check("bp_occ2", 32'(occ_a), 32'd2);
        rdy_in_a = 1'b1; step();
        check("bp_drain1", dout_a, 32'h21);
        check("bp_drain1_occ", 32'(occ_a), 32'd1);
        step();
        check("bp_drain2", dout_a, 32'h22);
        vin_a = 1'b0; step();
        check("bp_empty", 32'(vout_a), 32'd0);

        // Flush while FULL with a pending input
        drive_a(1'b1, 32'h30, 1'b0); step();
        drive_a(1'b1, 32'h31, 1'b0); step();
        check("fl_pre_occ", 32'(occ_a), 32'd2);
        drive_a(1'b1, 32'h32, 1'b0); flush_a = 1'b1; step();
        flush_a = 1'b0;
        check("fl_valid", 32'(vout_a), 32'd0);
        check("fl_ctrl", 32'(cout_a), 32'd0);
        check("fl_occ", 32'(occ_a), 32'd0);
        check("fl_ready", 32'(rdy_out_a), 32'd1);
        vin_a = 1'b1; din_a = 32'h55; cin_a = 3'b011; rdy_in_a = 1'b1; step();
        check("fl_next_data", dout_a, 32'h55);
        check("fl_next_ctrl", 32'(cout_a), 32'd3);
        vin_a = 1'b0; step();

        // Asynchronous reset mid-cycle while FULL
        drive_a(1'b1, 32'h40, 1'b0); step();
        drive_a(1'b1, 32'h41, 1'b0); step();
        drive_a(1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(vout_a), 32'd0);
        check("ar_occ", 32'(occ_a), 32'd0);
        check("ar_ready", 32'(rdy_out_a), 32'd0);
        check("ar_data", dout_a, 32'd0);
        check("ar_ctrl", 32'(cout_a), 32'd0);
        step();
        rst_n = 1'b1;
        drive_a(1'b1, 32'h60, 1'b1);
        step();
        check("ar_rel_ready", 32'(rdy_out_a), 32'd1);
        check("ar_rel_valid", 32'(vout_a), 32'd0);
        step();
        check("ar_first_data", dout_a, 32'h60);
        vin_a = 1'b0; step(); step();

        // Non-skid instance with downstream ready toggling every cycle
        pushed = 0;
        for (int cyc = 0; cyc < 40 && pushed < 6; cyc++) begin
            vin_b = 1'b1; din_b = 32'h70 + 32'(pushed); cin_b = 3'(pushed + 1);
            rdy_in_b = cyc[0];
            step();
            check("ns_occ_le1", 32'(occ_b <= 2'd1), 32'd1);
            if (acc_b_last) pushed++;
        end
        check("ns_all_accepted", 32'(pushed), 32'd6);
        vin_b = 1'b0; rdy_in_b = 1'b1;
        step(); step();
        check("ns_all_emitted", 32'(emitted_b), 32'd6);

        // Random traffic; upstream holds an entry until the model says it was taken
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!(vin_a && !acc_a_last)) begin
                vin_a = ($urandom_range(0, 9) < 7);
                din_a = $urandom;
                cin_a = 3'($urandom);
            end
            if (!(vin_b && !acc_b_last)) begin
                vin_b = ($urandom_range(0, 9) < 7);
                din_b = $urandom;
                cin_b = 3'($urandom);
            end
            rdy_in_a = ($urandom_range(0, 9) < 6);
            rdy_in_b = ($urandom_range(0, 9) < 6);
            flush_a  = ($urandom_range(0, 99) < 3);
            flush_b  = ($urandom_range(0, 99) < 3);
            step();
        end
        flush_a = 1'b0; flush_b = 1'b0;
        vin_a = 1'b0; vin_b = 1'b0;
        rdy_in_a = 1'b1; rdy_in_b = 1'b1;
        step(); step(); step();
        check("end_a_empty", 32'(occ_a), 32'd0);
        check("end_b_empty", 32'(occ_b), 32'd0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
